buffer_arbiter: RTL and testbench
=================================

# buffer_arbiter

Round-robin arbiter that shares one four-phase ready/done sink between `NUM_REQ` producers. Typically the sink is a single-entry `buffer` stage. Each producer sees an ordinary sink port. The arbiter grants one producer, captures its word, completes that producer's handshake, then replays the word downstream on its own ready/done port. It sits directly in front of the shared buffer stage in the memory path.

## Interface
- `DATA_BITWIDTH`, default 8: width of one data word.
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_data`  in  NUM_REQ*DATA_BITWIDTH  requester words; requester i occupies bits [i*DATA_BITWIDTH +: DATA_BITWIDTH].
- `req_ready`  in  NUM_REQ  per-requester "data valid, please take" level.
- `req_done`  out  NUM_REQ  per-requester capture acknowledge; at most one bit high at a time.
- `data_out`  out  DATA_BITWIDTH  registered captured word, to the sink's `data_in`.
- `ready_out`  out  1  to the sink's `ready_in`.
- `done_out`  in  1  from the sink's `done_in`.
- `grant_id`  out  ID_W  index of the current or most recent grant.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Handshake protocol, on both sides:
  - The source raises ready with data stable.
  - The sink raises done.
  - The source drops ready.
  - The sink drops done.
  - A new transfer starts only after done is seen low.
- The FSM has four states, registered and one transition per cycle at most:
  - **IDLE**: if any `req_ready` bit is high, pick the winner, latch `req_data[winner]` into `data_out`, set `grant_id`=winner, raise `req_done[winner]`, and go to ACK_IN. Otherwise stay in IDLE.
  - **ACK_IN**: when `req_ready[grant_id]`=0, clear `req_done`, raise `ready_out`, and go to SEND.
  - **SEND**: when `done_out`=1, clear `ready_out` and go to RELEASE.
  - **RELEASE**: when `done_out`=0, set `last_grant`=`grant_id` and go to IDLE.
- Round-robin rule:
  - The search starts at (`last_grant`+1) mod NUM_REQ and ascends with wrap-around.
  - The first set `req_ready` bit wins.
  - `last_grant` resets to NUM_REQ-1, so requester 0 has first priority after reset.
- `req_ready` of non-granted requesters is ignored outside IDLE; their `req_done` bits stay 0. A requester held off this way is served in a later IDLE evaluation.
- `data_out` changes only on the IDLE→ACK_IN edge. It is stable throughout SEND and RELEASE.
- `done_out` seen high in IDLE or ACK_IN is a protocol error by the sink. It is ignored, with no state change.
- When `req_ready[grant_id]` stays high in ACK_IN, the arbiter waits indefinitely. There is no timeout.

## Timing
- Reset values (asynchronous, immediate on `rst`):
  - state=IDLE
  - `req_done`=0
  - `ready_out`=0
  - `data_out`=0
  - `grant_id`=0
  - `last_grant`=NUM_REQ-1
  - `busy`=0
- Reset mid-transfer drops `ready_out` and `req_done` immediately. The captured word is lost, and the sink sees an aborted handshake.
- The `req_ready` sampled in IDLE at edge N produces `req_done` high after edge N. Nothing sits combinationally between `req_ready` and `req_done`.
- The `req_ready` low sampled at edge M gives `req_done` low and `ready_out` high after M. Capture of the upstream drop and downstream launch therefore take one cycle.
- The `done_out` high sampled at edge K gives `ready_out` low after K.
- The `done_out` low sampled at edge L returns the FSM to IDLE after L. A new grant is possible at edge L+1.
- All outputs are registered except `busy`, which is decoded from state.
- Minimum transfer with immediate peers: 4 cycles per word. There is no overlap between transfers.

## Structure
- A shared package `buffer_pkg` holds:
  - the FSM state localparams (IDLE/ACK_IN/SEND/RELEASE, 2-bit encoding);
  - the handshake-phase constants reused by other `buffer`-family blocks.
- A sub-module `rr_pick` computes the winner index and an any-request flag from `req_ready` and `last_grant`. It is purely combinational and parameterised on NUM_REQ.
- The top level holds the FSM, the data register, and the `req_done`/`ready_out` registers.

## Test plan
- Single requester 2: raise `req_ready[2]` with 0xA5, sink acknowledges instantly → `req_done[2]` high 1 cycle after the request, `ready_out` high with `data_out`=0xA5, `grant_id`=2, back to IDLE in 4 cycles.
- All four requesting continuously after reset → grants in order 0,1,2,3,0. Each `data_out` matches that requester's word.
- Requesters 1 and 3 assert in the same cycle with `last_grant`=1 → 3 is granted first, 1 next.
- Sink holds `done_out` low for 10 cycles in SEND → `ready_out` and `data_out` stay stable. No other `req_done` bit rises. New `req_ready` bits are served only after RELEASE.
- `rst` pulsed during SEND → `ready_out`, `req_done` and `busy` fall without waiting for a clock edge. The next grant after release goes to requester 0.
- Granted requester keeps `req_ready` high for 5 cycles in ACK_IN → `req_done` stays high, `ready_out` stays 0 until the drop.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer family: four-phase handshake phase codes
// and the arbiter FSM state type built on them.
package buffer_pkg;

    // Phase of a four-phase ready/done handshake as seen by the source side.
    localparam logic [1:0] HS_IDLE   = 2'd0;  // ready low, done low
    localparam logic [1:0] HS_OFFER  = 2'd1;  // ready high, waiting for done
    localparam logic [1:0] HS_ACKED  = 2'd2;  // done raised, waiting for ready to drop
    localparam logic [1:0] HS_RETIRE = 2'd3;  // ready dropped, waiting for done to drop

    localparam logic [1:0] ST_IDLE_ENC    = HS_IDLE;
    localparam logic [1:0] ST_ACK_IN_ENC  = HS_ACKED;
    localparam logic [1:0] ST_SEND_ENC    = HS_OFFER;
    localparam logic [1:0] ST_RELEASE_ENC = HS_RETIRE;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ACK_IN  = ST_ACK_IN_ENC,
        ST_SEND    = ST_SEND_ENC,
        ST_RELEASE = ST_RELEASE_ENC
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: starts one above last_grant and
// ascends with wrap-around; the first set request bit wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_ready,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    logic        found;
    int unsigned idx;

    // NOTE: every variable written here gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req_ready[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign any_req = |req_ready;

endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin arbiter sharing one four-phase ready/done sink between NUM_REQ
// producers: grant, capture, complete upstream, then replay the word downstream.
module buffer_arbiter
    import buffer_pkg::*;
#(
    parameter int DATA_BITWIDTH = 8,
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ*DATA_BITWIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [DATA_BITWIDTH-1:0]         data_out,
    output logic                             ready_out,
    input  logic                             done_out,
    output logic [ID_W-1:0]                  grant_id,
    output logic                             busy
);

    arb_state_e               state_q, state_d;
    logic [DATA_BITWIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [ID_W-1:0]          last_q, last_d;
    logic [NUM_REQ-1:0]       req_done_q, req_done_d;
    logic                     ready_q, ready_d;

    logic [ID_W-1:0]          winner;
    logic                     any_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_ready  (req_ready),
        .last_grant (last_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        grant_d    = grant_q;
        last_d     = last_q;
        req_done_d = req_done_q;
        ready_d    = ready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    data_d             = req_data[int'(winner)*DATA_BITWIDTH +: DATA_BITWIDTH];
                    grant_d            = winner;
                    req_done_d         = '0;
                    req_done_d[winner] = 1'b1;
                    state_d            = ST_ACK_IN;
                end
            end
            // done_out is a sink protocol error here and is deliberately ignored.
            ST_ACK_IN: begin
                if (!req_ready[grant_q]) begin
                    req_done_d = '0;
                    ready_d    = 1'b1;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (done_out) begin
                    ready_d = 1'b0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!done_out) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            grant_q    <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            req_done_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            req_done_q <= req_done_d;
            ready_q    <= ready_d;
        end
    end

    assign req_done  = req_done_q;
    assign data_out  = data_q;
    assign ready_out = ready_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed-vector bench for buffer_arbiter; the bench plays all producers
// and the downstream sink, with hand-computed expectations.
module tb_buffer_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_done;
    logic [DW-1:0]     data_out;
    logic              ready_out;
    logic              done_out;
    logic [IW-1:0]     grant_id;
    logic              busy;

    int vectors;
    int miscompares;

    buffer_arbiter #(
        .DATA_BITWIDTH (DW),
        .NUM_REQ       (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_done  (req_done),
        .data_out  (data_out),
        .ready_out (ready_out),
        .done_out  (done_out),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int id, input logic [DW-1:0] w);
        req_data[id*DW +: DW] = w;
    endtask

    // Run one full transfer from IDLE with the sink acknowledging at once.
    // The caller has already raised req_ready for the expected winner.
    task automatic serve(input int id, input logic [DW-1:0] word, input bit rerequest);
        step();
        check("grant_id", 32'(grant_id), 32'(id));
        check("req_done_grant", 32'(req_done), 32'(1) << id);
        check("data_capture", 32'(data_out), 32'(word));
        check("ready_low_ack", 32'(ready_out), 32'(0));
        req_ready[id] = 1'b0;
        step();
        check("req_done_clear", 32'(req_done), 32'(0));
        check("ready_launch", 32'(ready_out), 32'(1));
        done_out = 1'b1;
        step();
        check("ready_drop", 32'(ready_out), 32'(0));
        check("busy_release", 32'(busy), 32'(1));
        done_out = 1'b0;
        step();
        check("busy_idle", 32'(busy), 32'(0));
        if (rerequest) req_ready[id] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        req_ready   = '0;
        req_data    = '0;
        done_out    = 1'b0;
        #3;
        check("rst_req_done", 32'(req_done), 32'(0));
        check("rst_ready", 32'(ready_out), 32'(0));
        check("rst_data", 32'(data_out), 32'(0));
        check("rst_grant", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        step();
        rst = 1'b0;

        // Single requester 2, word A5, instant sink: four cycles IDLE to IDLE.
        set_word(2, 8'hA5);
        req_ready = 4'b0100;
        serve(2, 8'hA5, 1'b0);

        // All four requesting continuously after reset: 0,1,2,3,0.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_word(0, 8'h11);
        set_word(1, 8'h22);
        set_word(2, 8'h33);
        set_word(3, 8'h44);
        req_ready = 4'b1111;
        serve(0, 8'h11, 1'b1);
        serve(1, 8'h22, 1'b1);
        serve(2, 8'h33, 1'b1);
        serve(3, 8'h44, 1'b1);
        serve(0, 8'h11, 1'b0);
        req_ready = 4'b0000;

        // Bring last_grant to 1, then 1 and 3 together: 3 first, then 1.
        req_ready = 4'b0010;
        serve(1, 8'h22, 1'b0);
        req_ready = 4'b1010;
        serve(3, 8'h44, 1'b0);
        serve(1, 8'h22, 1'b0);

        // Sink stalls 10 cycles in SEND while new requests arrive.
        set_word(2, 8'h3C);
        req_ready = 4'b0100;
        step();
        check("stall_grant", 32'(grant_id), 32'(2));
        req_ready = 4'b0000;
        step();
        check("stall_send", 32'(ready_out), 32'(1));
        req_ready = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_ready", 32'(ready_out), 32'(1));
            check("stall_data", 32'(data_out), 32'(8'h3C));
            check("stall_req_done", 32'(req_done), 32'(0));
        end
        done_out = 1'b1;
        step();
        check("stall_release", 32'(ready_out), 32'(0));
        check("stall_req_done_rel", 32'(req_done), 32'(0));
        done_out = 1'b0;
        step();
        check("stall_idle", 32'(busy), 32'(0));
        serve(3, 8'h44, 1'b0);
        serve(0, 8'h11, 1'b0);

        // Reset pulsed during SEND acts without a clock edge.
        set_word(1, 8'h77);
        req_ready = 4'b0010;
        step();
        check("rst_mid_grant", 32'(grant_id), 32'(1));
        req_ready = 4'b0000;
        step();
        check("rst_mid_send", 32'(ready_out), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_ready", 32'(ready_out), 32'(0));
        check("rst_mid_req_done", 32'(req_done), 32'(0));
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_data", 32'(data_out), 32'(0));
        #1;
        rst = 1'b0;
        req_ready = 4'b0101;
        serve(0, 8'h11, 1'b0);
        serve(2, 8'h3C, 1'b0);

        // Granted requester holds ready 5 cycles in ACK_IN; a stray done is ignored.
        set_word(1, 8'h5A);
        req_ready = 4'b0010;
        step();
        check("hold_grant", 32'(req_done), 32'(4'b0010));
        for (int i = 0; i < 5; i++) begin
            done_out = (i == 2);
            step();
            check("hold_req_done", 32'(req_done), 32'(4'b0010));
            check("hold_ready", 32'(ready_out), 32'(0));
        end
        done_out  = 1'b0;
        req_ready = 4'b0000;
        step();
        check("hold_drop_done", 32'(req_done), 32'(0));
        check("hold_launch", 32'(ready_out), 32'(1));
        check("hold_data", 32'(data_out), 32'(8'h5A));
        done_out = 1'b1;
        step();
        check("hold_ready_drop", 32'(ready_out), 32'(0));
        done_out = 1'b0;
        step();
        check("hold_idle", 32'(busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
